// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-addressed load/store front end for a word-addressed data memory
// Handles sub-word read-modify-write, load extension, alignment and address-range errors.
module load_store_unit #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [WORD_SIZE-1:0] req_address,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [WORD_SIZE-1:0] resp_rdata,
    output logic                 resp_err_align,
    output logic                 resp_err_addr,
    output logic                 mem_write_enabled,
    output logic                 mem_read_enabled,
    output logic [WORD_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0] mem_input_data,
    input  logic [WORD_SIZE-1:0] mem_output_data,
    input  logic                 mem_err_invalid_address
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROBE,
        S_CHECK,
        S_WRITE,
        S_RESP
    } state_t;

    state_t               state_q, state_d;
    logic                 write_q, write_d;
    logic [1:0]           size_q, size_d;
    logic                 signed_q, signed_d;
    logic [1:0]           offset_q, offset_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [WORD_SIZE-1:0] mem_address_q, mem_address_d;
    logic [WORD_SIZE-1:0] mem_input_data_q, mem_input_data_d;
    logic [WORD_SIZE-1:0] resp_rdata_q, resp_rdata_d;
    logic                 err_align_q, err_align_d;
    logic                 err_addr_q, err_addr_d;

    logic                 misaligned;
    logic [4:0]           lane_shift;
    logic [WORD_SIZE-1:0] lane_mask;
    logic [WORD_SIZE-1:0] merged_word;
    logic [WORD_SIZE-1:0] lane_data;
    logic                 lane_msb;
    logic [WORD_SIZE-1:0] load_word;

    assign misaligned = (req_size == 2'b11)
                     || (req_size == 2'b01 && req_address[0])
                     || (req_size == 2'b10 && req_address[1:0] != 2'b00);

    // Big-endian lanes: offset 0 is the most significant byte, so the shift is (3 - offset) bytes.
    always_comb begin
        lane_shift = 5'd0;
        lane_mask  = '1;
        lane_msb   = 1'b0;
        case (size_q)
            2'b00: begin
                lane_shift = {~offset_q, 3'b000};
                lane_mask  = {{(WORD_SIZE-8){1'b0}}, 8'hFF};
            end
            2'b01: begin
                lane_shift = {~offset_q[1], 4'b0000};
                lane_mask  = {{(WORD_SIZE-16){1'b0}}, 16'hFFFF};
            end
            default: begin
                lane_shift = 5'd0;
                lane_mask  = '1;
            end
        endcase
        merged_word = (mem_output_data & ~(lane_mask << lane_shift))
                    | ((wdata_q & lane_mask) << lane_shift);
        lane_data   = (mem_output_data >> lane_shift) & lane_mask;
        case (size_q)
            2'b00:   lane_msb = lane_data[7];
            2'b01:   lane_msb = lane_data[15];
            default: lane_msb = 1'b0;
        endcase
        load_word = (signed_q && lane_msb) ? (lane_data | ~lane_mask) : lane_data;
    end

    always_comb begin
        state_d          = state_q;
        write_d          = write_q;
        size_d           = size_q;
        signed_d         = signed_q;
        offset_d         = offset_q;
        wdata_d          = wdata_q;
        mem_address_d    = mem_address_q;
        mem_input_data_d = mem_input_data_q;
        resp_rdata_d     = resp_rdata_q;
        err_align_d      = err_align_q;
        err_addr_d       = err_addr_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    size_d   = req_size;
                    signed_d = req_signed;
                    offset_d = req_address[1:0];
                    wdata_d  = req_wdata;
                    if (misaligned) begin
                        resp_rdata_d = '0;
                        err_align_d  = 1'b1;
                        err_addr_d   = 1'b0;
                        state_d      = S_RESP;
                    end else begin
                        mem_address_d = {2'b00, req_address[WORD_SIZE-1:2]};
                        state_d       = S_PROBE;
                    end
                end
            end
            S_PROBE: state_d = S_CHECK;
            S_CHECK: begin
                if (mem_err_invalid_address) begin
                    resp_rdata_d = '0;
                    err_align_d  = 1'b0;
                    err_addr_d   = 1'b1;
                    state_d      = S_RESP;
                end else if (write_q) begin
                    mem_input_data_d = merged_word;
                    state_d          = S_WRITE;
                end else begin
                    resp_rdata_d = load_word;
                    err_align_d  = 1'b0;
                    err_addr_d   = 1'b0;
                    state_d      = S_RESP;
                end
            end
            S_WRITE: begin
                resp_rdata_d = '0;
                err_align_d  = 1'b0;
                err_addr_d   = 1'b0;
                state_d      = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            write_q          <= 1'b0;
            size_q           <= 2'b00;
            signed_q         <= 1'b0;
            offset_q         <= 2'b00;
            wdata_q          <= '0;
            mem_address_q    <= '0;
            mem_input_data_q <= '0;
            resp_rdata_q     <= '0;
            err_align_q      <= 1'b0;
            err_addr_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            write_q          <= write_d;
            size_q           <= size_d;
            signed_q         <= signed_d;
            offset_q         <= offset_d;
            wdata_q          <= wdata_d;
            mem_address_q    <= mem_address_d;
            mem_input_data_q <= mem_input_data_d;
            resp_rdata_q     <= resp_rdata_d;
            err_align_q      <= err_align_d;
            err_addr_q       <= err_addr_d;
        end
    end

    // Enables decode straight from state so an asynchronous reset drops them at once.
    assign req_ready         = (state_q == S_IDLE);
    assign mem_read_enabled  = (state_q == S_PROBE) || (state_q == S_CHECK);
    assign mem_write_enabled = (state_q == S_WRITE);
    assign resp_valid        = (state_q == S_RESP);
    assign mem_address       = mem_address_q;
    assign mem_input_data    = mem_input_data_q;
    assign resp_rdata        = resp_rdata_q;
    assign resp_err_align    = err_align_q;
    assign resp_err_addr     = err_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - vector table, reset-abort sequence and random model check for load_store_unit
module tb_load_store_unit;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err_align;
    logic        resp_err_addr;
    logic        mem_write_enabled;
    logic        mem_read_enabled;
    logic [31:0] mem_address;
    logic [31:0] mem_input_data;
    logic [31:0] mem_output_data;
    logic        mem_err_invalid_address;

    int total;
    int bad;

    load_store_unit #(.WORD_SIZE(32)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .req_valid               (req_valid),
        .req_ready               (req_ready),
        .req_write               (req_write),
        .req_size                (req_size),
        .req_signed              (req_signed),
        .req_address             (req_address),
        .req_wdata               (req_wdata),
        .resp_valid              (resp_valid),
        .resp_rdata              (resp_rdata),
        .resp_err_align          (resp_err_align),
        .resp_err_addr           (resp_err_addr),
        .mem_write_enabled       (mem_write_enabled),
        .mem_read_enabled        (mem_read_enabled),
        .mem_address             (mem_address),
        .mem_input_data          (mem_input_data),
        .mem_output_data         (mem_output_data),
        .mem_err_invalid_address (mem_err_invalid_address)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word-addressed data memory, 1024 words, with a registered range error flag.
    logic [31:0] env_mem [0:1023];
    logic [31:0] ld_img  [0:1023];
    logic        ld_all;

    always @(posedge clock) begin
        if (ld_all) begin
            for (int i = 0; i < 1024; i++) env_mem[i] <= ld_img[i];
        end else if (mem_write_enabled && mem_address < 32'd1024) begin
            env_mem[mem_address[9:0]] <= mem_input_data;
        end
        mem_err_invalid_address <= (mem_address >= 32'd1024);
    end
    assign mem_output_data = (mem_address < 32'd1024) ? env_mem[mem_address[9:0]] : 32'h0;

    // Reference model: flat byte array, big-endian within each word.
    logic [7:0] model_bytes [0:4095];

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_al;
        logic        exp_ae;
        int          exp_lat;
        int          exp_wr;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic load_image();
        @(negedge clock);
        ld_all = 1'b1;
        @(posedge clock);
        #1 ld_all = 1'b0;
    endtask

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic al, output logic ae,
                          output int lat, output int wrs);
        lat = 0;
        wrs = 0;
        rd  = 32'hx;
        al  = 1'bx;
        ae  = 1'bx;
        @(negedge clock);
        check("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
        req_valid   = 1'b1;
        req_write   = wr;
        req_size    = sz;
        req_signed  = sg;
        req_address = addr;
        req_wdata   = wd;
        @(posedge clock);
        #1 req_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            if (mem_write_enabled) wrs++;
            if (resp_valid) begin
                lat = i;
                rd  = resp_rdata;
                al  = resp_err_align;
                ae  = resp_err_addr;
                break;
            end
        end
        if (lat == 0) $display("FAIL resp_timeout: no resp_valid within 8 cycles, expected one");
        @(negedge clock);
        check("resp_valid_one_cycle", {31'b0, resp_valid}, 32'd0);
    endtask

    task automatic model_expect(input logic wr, input logic [1:0] sz, input logic sg,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] rd, output logic al, output logic ae,
                                output int lat, output int wrs);
        int          n;
        logic [63:0] v;
        n  = 1 << sz;
        al = (sz == 2'd3) || ((addr % n) != 0);
        ae = !al && (addr >= 32'h1000);
        rd = 32'h0;
        if (al)      lat = 1;
        else if (ae) lat = 3;
        else if (wr) lat = 4;
        else         lat = 3;
        wrs = (!al && !ae && wr) ? 1 : 0;
        if (!al && !ae) begin
            if (wr) begin
                for (int k = 0; k < n; k++)
                    model_bytes[addr + k] = 8'((wd >> (8 * (n - 1 - k))) & 32'hFF);
            end else begin
                v = 0;
                for (int k = 0; k < n; k++) v = (v << 8) | 64'(model_bytes[addr + k]);
                if (sg && n < 4 && v[8*n-1]) v = v - (64'd1 << (8 * n));
                rd = v[31:0];
            end
        end
    endtask

    logic [31:0] a_rd, e_rd;
    logic        a_al, a_ae, e_al, e_ae;
    int          a_lat, a_wr, e_lat, e_wr;
    int          saw_resp;
    int          word_bad;

    initial begin
        total       = 0;
        bad         = 0;
        ld_all      = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_size    = 2'b00;
        req_signed  = 1'b0;
        req_address = 32'h0;
        req_wdata   = 32'h0;
        reset       = 1'b1;

        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,   32'h11223344, 32'h0,        1'b0, 1'b0, 4, 1};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'h11223344, 1'b0, 1'b0, 3, 0};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h11,   32'hFFFFFFAB, 32'h0,        1'b0, 1'b0, 4, 1};
        vecs[3]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'h11AB3344, 1'b0, 1'b0, 3, 0};
        vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h11,   32'h0,        32'hFFFFFFAB, 1'b0, 1'b0, 3, 0};
        vecs[5]  = '{1'b0, 2'd0, 1'b0, 32'h11,   32'h0,        32'h000000AB, 1'b0, 1'b0, 3, 0};
        vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h12,   32'h0,        32'h00003344, 1'b0, 1'b0, 3, 0};
        vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h13,   32'h00005555, 32'h0,        1'b1, 1'b0, 1, 0};
        vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'h11AB3344, 1'b0, 1'b0, 3, 0};
        vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'h1000, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 3, 0};
        vecs[10] = '{1'b0, 2'd0, 1'b1, 32'h13,   32'h0,        32'h00000044, 1'b0, 1'b0, 3, 0};
        vecs[11] = '{1'b1, 2'd1, 1'b0, 32'h12,   32'h12348000, 32'h0,        1'b0, 1'b0, 4, 1};
        vecs[12] = '{1'b0, 2'd1, 1'b1, 32'h12,   32'h0,        32'hFFFF8000, 1'b0, 1'b0, 3, 0};
        vecs[13] = '{1'b0, 2'd1, 1'b1, 32'h10,   32'h0,        32'h000011AB, 1'b0, 1'b0, 3, 0};
        vecs[14] = '{1'b0, 2'd3, 1'b0, 32'h10,   32'h0,        32'h0,        1'b1, 1'b0, 1, 0};
        vecs[15] = '{1'b0, 2'd2, 1'b0, 32'h12,   32'h0,        32'h0,        1'b1, 1'b0, 1, 0};
        vecs[16] = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'h11AB8000, 1'b0, 1'b0, 3, 0};
        vecs[17] = '{1'b0, 2'd0, 1'b0, 32'h2000, 32'h0,        32'h0,        1'b0, 1'b1, 3, 0};

        for (int i = 0; i < 1024; i++) ld_img[i] = 32'h0;
        repeat (2) @(posedge clock);
        #2;
        check("reset_req_ready",      {31'b0, req_ready},         32'd1);
        check("reset_resp_valid",     {31'b0, resp_valid},        32'd0);
        check("reset_resp_rdata",     resp_rdata,                 32'd0);
        check("reset_mem_address",    mem_address,                32'd0);
        check("reset_mem_input_data", mem_input_data,             32'd0);
        check("reset_write_enabled",  {31'b0, mem_write_enabled}, 32'd0);
        check("reset_read_enabled",   {31'b0, mem_read_enabled},  32'd0);
        @(negedge clock);
        reset = 1'b0;
        load_image();

        foreach (vecs[i]) begin
            do_req(vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wd,
                   a_rd, a_al, a_ae, a_lat, a_wr);
            check($sformatf("vec%0d_rdata", i),     a_rd,           vecs[i].exp_rd);
            check($sformatf("vec%0d_err_align", i), {31'b0, a_al},  {31'b0, vecs[i].exp_al});
            check($sformatf("vec%0d_err_addr", i),  {31'b0, a_ae},  {31'b0, vecs[i].exp_ae});
            check($sformatf("vec%0d_latency", i),   32'(a_lat),     32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_write_pulses", i), 32'(a_wr),   32'(vecs[i].exp_wr));
        end
        check("mem_word4_after_table", env_mem[4], 32'h11AB8000);

        // Reset during the WRITE cycle of a word store to 0x20.
        @(negedge clock);
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_size    = 2'd2;
        req_signed  = 1'b0;
        req_address = 32'h20;
        req_wdata   = 32'hCAFEF00D;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("abort_in_write", {31'b0, mem_write_enabled}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_write_enabled",  {31'b0, mem_write_enabled}, 32'd0);
        check("abort_read_enabled",   {31'b0, mem_read_enabled},  32'd0);
        check("abort_mem_address",    mem_address,                32'd0);
        check("abort_mem_input_data", mem_input_data,             32'd0);
        check("abort_resp_valid",     {31'b0, resp_valid},        32'd0);
        check("abort_resp_rdata",     resp_rdata,                 32'd0);
        check("abort_resp_errs",      {30'b0, resp_err_align, resp_err_addr}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("abort_req_ready", {31'b0, req_ready}, 32'd1);
        saw_resp = 0;
        repeat (6) begin
            @(negedge clock);
            if (resp_valid) saw_resp++;
        end
        check("abort_no_resp", 32'(saw_resp), 32'd0);
        check("abort_mem_word8", env_mem[8], 32'h0);

        // Random traffic against the byte-array model on a random memory image.
        for (int i = 0; i < 1024; i++) begin
            ld_img[i] = $urandom;
            for (int k = 0; k < 4; k++) model_bytes[4*i + k] = ld_img[i][31-8*k -: 8];
        end
        load_image();
        for (int t = 0; t < 300; t++) begin
            logic        wr, sg;
            logic [1:0]  sz;
            logic [31:0] addr, wd;
            wr   = 1'($urandom_range(0, 1));
            sg   = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 2) != 0) begin
                if (sz == 2'd1) addr[0] = 1'b0;
                if (sz == 2'd2) addr[1:0] = 2'b00;
            end
            wd = $urandom;
            model_expect(wr, sz, sg, addr, wd, e_rd, e_al, e_ae, e_lat, e_wr);
            do_req(wr, sz, sg, addr, wd, a_rd, a_al, a_ae, a_lat, a_wr);
            check($sformatf("rnd%0d_rdata", t),     a_rd,          e_rd);
            check($sformatf("rnd%0d_errs", t),      {30'b0, a_al, a_ae}, {30'b0, e_al, e_ae});
            check($sformatf("rnd%0d_latency", t),   32'(a_lat),    32'(e_lat));
            check($sformatf("rnd%0d_writes", t),    32'(a_wr),     32'(e_wr));
        end
        word_bad = 0;
        for (int i = 0; i < 1024; i++)
            if (env_mem[i] !== {model_bytes[4*i], model_bytes[4*i+1], model_bytes[4*i+2], model_bytes[4*i+3]})
                word_bad++;
        check("final_memory_words_differing", 32'(word_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
